mem_arb: RTL and testbench

Single-port memory arbiter for the SISC datapath. It shares one unified synchronous memory between the instruction-fetch path (PC to IR load) and the data load/store path. At most one access is issued per cycle, and read data returns with a fixed one-cycle latency to whichever requester owned the access. Data accesses normally win, and a starvation counter guarantees fetch forward progress.

---
 rtl/mem_arb.sv | 92 +++++++++
 tb/tb_mem_arb.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - single-port memory arbiter between instruction fetch and data load/store
// Data wins by default; a saturating starvation counter forces a fetch grant after STARVE data grants.
module mem_arb #(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 32,
  parameter int unsigned STARVE = 4
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  logic [3:0] starve_cnt;
  owner_t     owner;
  logic       fetch_win;
  logic       data_win;
  logic       fetch_starved;

  assign fetch_starved = if_req && (starve_cnt == STARVE_MAX);

  // Grants are forced low while reset is held so nothing reaches memory.
  always_comb begin
    fetch_win = 1'b0;
    data_win  = 1'b0;
    if (!rst_f) begin
      if (d_req && !fetch_starved) begin
        data_win = 1'b1;
      end else if (if_req) begin
        fetch_win = 1'b1;
      end
    end
  end

  assign if_gnt    = fetch_win;
  assign d_gnt     = data_win;
  assign mem_en    = fetch_win | data_win;
  assign mem_we    = data_win & d_we;
  assign mem_addr  = data_win ? d_addr : (fetch_win ? if_addr : '0);
  assign mem_wdata = data_win ? d_wdata : '0;

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      starve_cnt <= 4'd0;
      owner      <= OWN_NONE;
    end else begin
      if (fetch_win || !if_req) begin
        starve_cnt <= 4'd0;
      end else if (data_win && (starve_cnt < STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      // Writes return nothing, so only reads claim the next-cycle read data.
      if (fetch_win) begin
        owner <= OWN_FETCH;
      end else if (data_win && !d_we) begin
        owner <= OWN_DATA;
      end else begin
        owner <= OWN_NONE;
      end
    end
  end

  assign if_rvalid = (owner == OWN_FETCH);
  assign d_rvalid  = (owner == OWN_DATA);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - directed self-checking bench for mem_arb
// Includes a small synchronous memory model with one-cycle read latency.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arb #(.AW(16), .DW(32), .STARVE(4)) dut (
    .clk(clk), .rst_f(rst_f),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic        written [256] = '{default: 1'b0};

  function automatic logic [31:0] init_word(input logic [7:0] a);
    return (a == 8'h10) ? 32'h1234ABCD : (32'hA500_0000 | {24'h0, a});
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr[7:0]]     <= mem_wdata;
        written[mem_addr[7:0]] <= 1'b1;
      end else begin
        mem_rdata <= written[mem_addr[7:0]] ? mem[mem_addr[7:0]] : init_word(mem_addr[7:0]);
      end
    end
  end

  task automatic drop_reqs();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0010; d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0022; d_wdata = 32'h5555AAAA;
    rst_f = 1'b1;
    #1;
    n_tests++; if (if_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_if_gnt: got %b want 0", if_gnt); end
    n_tests++; if (d_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_d_gnt: got %b want 0", d_gnt); end
    n_tests++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en_we: got %b%b want 00", mem_en, mem_we); end
    n_tests++; if (mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_bus: got %h %h want 0 0", mem_addr, mem_wdata); end
    @(negedge clk); #1;
    n_tests++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b%b want 00", if_rvalid, d_rvalid); end
    n_tests++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h %h want 0 0", if_rdata, d_rdata); end
    @(negedge clk);
    rst_f = 1'b0;
    #1;
    n_tests++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_release_gnt: got d=%b if=%b want d=1 if=0", d_gnt, if_gnt); end
    drop_reqs();
  endtask

  task automatic test_fetch_read();
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0010;
    #1;
    n_tests++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin n_fail++; $display("FAIL fetch_gnt: got if=%b d=%b want if=1 d=0", if_gnt, d_gnt); end
    n_tests++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0010) begin n_fail++; $display("FAIL fetch_mem: got en=%b we=%b addr=%h want 1 0 0010", mem_en, mem_we, mem_addr); end
    @(negedge clk);
    drop_reqs();
    #1;
    n_tests++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1234ABCD) begin n_fail++; $display("FAIL fetch_rdata: got v=%b %h want v=1 1234abcd", if_rvalid, if_rdata); end
    n_tests++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_no_d_rvalid: got %b want 0", d_rvalid); end
    @(negedge clk); #1;
    n_tests++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin n_fail++; $display("FAIL fetch_rvalid_drop: got v=%b %h want v=0 0", if_rvalid, if_rdata); end
  endtask

  task automatic test_data_write_read();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 32'hDEADBEEF;
    #1;
    n_tests++; if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 16'h0020) begin n_fail++; $display("FAIL write_mem: got gnt=%b we=%b wd=%h a=%h want 1 1 deadbeef 0020", d_gnt, mem_we, mem_wdata, mem_addr); end
    @(negedge clk);
    d_we = 1'b0; d_wdata = 32'h0;
    #1;
    n_tests++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin n_fail++; $display("FAIL write_no_rvalid: got d=%b if=%b want 0 0", d_rvalid, if_rvalid); end
    n_tests++; if (d_gnt !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL read_after_write_gnt: got gnt=%b we=%b want 1 0", d_gnt, mem_we); end
    @(negedge clk);
    drop_reqs();
    #1;
    n_tests++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_after_write_data: got v=%b %h want v=1 deadbeef", d_rvalid, d_rdata); end
    @(negedge clk); #1;
    n_tests++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL read_rvalid_drop: got v=%b %h want v=0 0", d_rvalid, d_rdata); end
  endtask

  // Bit i set means fetch should win cycle i with both requests held.
  task automatic test_starvation();
    logic [9:0] pat;
    pat = 10'b10_0001_0000;
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0040; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_tests++; if (if_gnt !== pat[i] || d_gnt !== !pat[i]) begin n_fail++; $display("FAIL starve_gnt[%0d]: got if=%b d=%b want if=%b d=%b", i, if_gnt, d_gnt, pat[i], !pat[i]); end
      if (i > 0) begin
        n_tests++; if (if_rvalid !== pat[i-1] || d_rvalid !== !pat[i-1]) begin n_fail++; $display("FAIL starve_rvalid[%0d]: got if=%b d=%b want if=%b d=%b", i, if_rvalid, d_rvalid, pat[i-1], !pat[i-1]); end
        n_tests++; if ((pat[i-1] ? if_rdata : d_rdata) !== (pat[i-1] ? 32'hA500_0040 : 32'hA500_0030)) begin n_fail++; $display("FAIL starve_rdata[%0d]: got if=%h d=%h", i, if_rdata, d_rdata); end
      end
    end
    @(negedge clk);
    drop_reqs();
    #1;
    n_tests++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA500_0040 || d_rvalid !== 1'b0) begin n_fail++; $display("FAIL starve_last: got if=%b %h d=%b want 1 a5000040 0", if_rvalid, if_rdata, d_rvalid); end
  endtask

  task automatic test_interleave();
    logic [15:0] prev_addr;
    logic        prev_fetch;
    prev_addr = '0; prev_fetch = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 6) drop_reqs();
      else if (i % 2 == 0) begin if_req = 1'b1; if_addr = 16'h0050 + 16'(i); d_req = 1'b0; end
      else begin d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0060 + 16'(i); if_req = 1'b0; end
      #1;
      if (i < 6) begin
        n_tests++; if (if_gnt !== (i % 2 == 0) || d_gnt !== (i % 2 == 1)) begin n_fail++; $display("FAIL inter_gnt[%0d]: got if=%b d=%b", i, if_gnt, d_gnt); end
      end
      if (i > 0) begin
        n_tests++; if (if_rvalid !== prev_fetch || d_rvalid !== !prev_fetch) begin n_fail++; $display("FAIL inter_rvalid[%0d]: got if=%b d=%b want if=%b", i, if_rvalid, d_rvalid, prev_fetch); end
        n_tests++; if ((prev_fetch ? if_rdata : d_rdata) !== (32'hA500_0000 | {16'h0, prev_addr})) begin n_fail++; $display("FAIL inter_rdata[%0d]: got if=%h d=%h want %h", i, if_rdata, d_rdata, 32'hA500_0000 | {16'h0, prev_addr}); end
      end
      prev_fetch = (i % 2 == 0);
      prev_addr  = (i % 2 == 0) ? 16'h0050 + 16'(i) : 16'h0060 + 16'(i);
    end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    if_req = 1'b1; if_addr = 16'h0040; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030;
    @(negedge clk);
    @(negedge clk); #1;
    n_tests++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_gnt: got %b want 1", d_gnt); end
    #2 rst_f = 1'b1;
    #1;
    n_tests++; if (d_gnt !== 1'b0 || if_gnt !== 1'b0 || mem_en !== 1'b0) begin n_fail++; $display("FAIL midrst_gnt_off: got d=%b if=%b en=%b want 000", d_gnt, if_gnt, mem_en); end
    @(negedge clk); #1;
    n_tests++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h0 || if_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid: got d=%b %h if=%b want 0 0 0", d_rvalid, d_rdata, if_rvalid); end
    @(negedge clk);
    rst_f = 1'b0;
    // A cleared counter shows up as four data wins before the fetch.
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_tests++; if (if_gnt !== (i == 4) || d_gnt !== (i != 4)) begin n_fail++; $display("FAIL midrst_starve[%0d]: got if=%b d=%b want if=%b", i, if_gnt, d_gnt, (i == 4)); end
    end
    @(negedge clk);
    drop_reqs();
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_data_write_read();
    test_starvation();
    test_interleave();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
